// File: rtl/regs_jtag_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the register-file JTAG arbiter.
// The starvation-halt option is selected with REGS_ARB_STARVE_HALT_EN.
package regs_jtag_arbiter_pkg;

  localparam int REG_ADDR_BUS     = 5;
  localparam int REG_BUS          = 32;
  localparam int STARVE_LIMIT_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_PEND = 2'b01,
    ARB_ACK  = 2'b10
  } arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/regs_jtag_arbiter_if.sv
// JTAG debug access channel: request/capture fields from the host, ack/read data/busy back.
interface regs_jtag_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              jtag_req_i;
  logic              jtag_we_i;
  logic [ADDR_W-1:0] jtag_addr_i;
  logic [DATA_W-1:0] jtag_wdata_i;
  logic              jtag_ack_o;
  logic [DATA_W-1:0] jtag_rdata_o;
  logic              jtag_busy_o;

  modport master (
    output jtag_req_i, jtag_we_i, jtag_addr_i, jtag_wdata_i,
    input  jtag_ack_o, jtag_rdata_o, jtag_busy_o
  );

  modport slave (
    input  jtag_req_i, jtag_we_i, jtag_addr_i, jtag_wdata_i,
    output jtag_ack_o, jtag_rdata_o, jtag_busy_o
  );
endinterface

// File: rtl/regs_arb_starve_cnt.sv
// Saturating count of stalled JTAG-write cycles plus registered halt request.
// Only instantiated when REGS_ARB_STARVE_HALT_EN is defined.
module regs_arb_starve_cnt
  import regs_jtag_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  output logic halt_o
);

  localparam int unsigned      CNT_W   = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d;

  // A non-stalled cycle means the write issued or PEND was left, so both clear.
  always_comb begin
    cnt_d  = '0;
    halt_d = 1'b0;
    if (stall_i) begin
      cnt_d  = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + CNT_W'(1);
      halt_d = (cnt_q == LIMIT_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      halt_q <= halt_d;
    end
  end

  assign halt_o = halt_q;

endmodule

// File: rtl/regs_jtag_arbiter.sv
// Shares the register-file write/debug-read ports between core writeback and JTAG.
// Define REGS_ARB_STARVE_HALT_EN to build the starvation counter and halt request.
module regs_jtag_arbiter
  import regs_jtag_arbiter_pkg::*;
#(
  parameter int ADDR_W       = REG_ADDR_BUS,
  parameter int DATA_W       = REG_BUS,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_we_i,
  input  logic [ADDR_W-1:0]    ex_waddr_i,
  input  logic [DATA_W-1:0]    ex_wdata_i,
  regs_jtag_arbiter_if.slave   jtag,
  output logic                 rf_we_o,
  output logic [ADDR_W-1:0]    rf_waddr_o,
  output logic [DATA_W-1:0]    rf_wdata_o,
  output logic [ADDR_W-1:0]    rf_raddr_o,
  input  logic [DATA_W-1:0]    rf_rdata_i,
  output logic                 halt_req_o
);

  arb_state_e        state_q, state_d;
  logic              cap_we_q, cap_we_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic in_pend;
  logic cap_wr_nz;
  logic jtag_wr_issue;
  logic stall;

  always_comb begin
    in_pend       = (state_q == ARB_PEND);
    cap_wr_nz     = cap_we_q && (cap_addr_q != '0);
    // Gated by rst so a reset landing in PEND never commits the captured write.
    jtag_wr_issue = in_pend && cap_wr_nz && !ex_we_i && !rst;
    stall         = in_pend && cap_wr_nz && ex_we_i;
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = cap_addr_q;
    rf_wdata_o = cap_wdata_q;
    if (ex_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
    end else if (jtag_wr_issue) begin
      rf_we_o = 1'b1;
    end
  end

  assign rf_raddr_o = (state_q == ARB_IDLE) ? '0 : cap_addr_q;

  always_comb begin
    state_d     = state_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (jtag.jtag_req_i) begin
          cap_we_d    = jtag.jtag_we_i;
          cap_addr_d  = jtag.jtag_addr_i;
          cap_wdata_d = jtag.jtag_wdata_i;
          state_d     = ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (!cap_we_q) begin
          // Forward a same-cycle ex write so the read sees the newest value.
          if (cap_addr_q == '0)
            rdata_d = '0;
          else if (ex_we_i && (ex_waddr_i == cap_addr_q))
            rdata_d = ex_wdata_i;
          else
            rdata_d = rf_rdata_i;
          state_d = ARB_ACK;
          ack_d   = 1'b1;
        end else if (!stall) begin
          state_d = ARB_ACK;
          ack_d   = 1'b1;
        end
      end
      ARB_ACK:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign jtag.jtag_ack_o   = ack_q;
  assign jtag.jtag_rdata_o = rdata_q;
  assign jtag.jtag_busy_o  = busy_q;

`ifdef REGS_ARB_STARVE_HALT_EN
  regs_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .halt_o  (halt_req_o)
  );
`else
  assign halt_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_regs_jtag_arbiter.sv
// Directed bench for regs_jtag_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_regs_jtag_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_we;
  logic [AW-1:0] ex_waddr;
  logic [DW-1:0] ex_wdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          halt;

  always #5 clk = ~clk;

  regs_jtag_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) jif ();

  regs_jtag_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_we_i    (ex_we),
    .ex_waddr_i (ex_waddr),
    .ex_wdata_i (ex_wdata),
    .jtag       (jif),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .rf_raddr_o (rf_raddr),
    .rf_rdata_i (rf_rdata),
    .halt_req_o (halt)
  );

  // Register file environment: asynchronous read, write on posedge.
  logic [DW-1:0] mem [32];
  logic          mem_init;
  assign rf_rdata = mem[rf_raddr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
    end else if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end

  int ack_cnt = 0;
  always @(posedge clk) if (jif.jtag_ack_o === 1'b1) ack_cnt <= ack_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Transaction model: one outstanding JTAG access, its stall count and pending ack.
  logic          m_valid = 1'b0;
  logic          m_act, m_wr, m_ack, m_halt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_stall;

  always @(negedge clk) begin : model
    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_halt;
    logic          done;
    if (m_valid) begin
      e_we    = 1'b0;
      e_waddr = '0;
      e_wdata = '0;
      if (ex_we) begin
        e_we = 1'b1; e_waddr = ex_waddr; e_wdata = ex_wdata;
      end else if (m_act && m_wr && m_addr != 0 && !rst) begin
        e_we = 1'b1; e_waddr = m_addr; e_wdata = m_wdata;
      end
`ifdef REGS_ARB_STARVE_HALT_EN
      e_halt = m_halt;
`else
      e_halt = 1'b0;
`endif
      check("m_ack",   32'(jif.jtag_ack_o),  32'(m_ack));
      check("m_busy",  32'(jif.jtag_busy_o), 32'(m_act || m_ack));
      check("m_rdata", jif.jtag_rdata_o,     m_rdata);
      check("m_rf_we", 32'(rf_we),           32'(e_we));
      if (e_we) begin
        check("m_rf_waddr", 32'(rf_waddr), 32'(e_waddr));
        check("m_rf_wdata", rf_wdata,       e_wdata);
      end
      check("m_rf_raddr", 32'(rf_raddr), (m_act || m_ack) ? 32'(m_addr) : 32'd0);
      check("m_halt",     32'(halt),     32'(e_halt));
    end
    if (rst) begin
      m_valid = 1'b1;
      m_act = 1'b0; m_wr = 1'b0; m_ack = 1'b0; m_halt = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_stall = 0;
    end else if (m_valid) begin
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (m_act) begin
        done = 1'b0;
        if (!m_wr) begin
          if (m_addr == 0)                        m_rdata = '0;
          else if (ex_we && ex_waddr == m_addr)   m_rdata = ex_wdata;
          else                                    m_rdata = mem[m_addr];
          done = 1'b1;
        end else if (m_addr == 0 || !ex_we) begin
          done = 1'b1;
        end else begin
          m_halt = (m_stall == LIM);
          if (m_stall < LIM) m_stall++;
        end
        if (done) begin
          m_act = 1'b0; m_ack = 1'b1; m_stall = 0; m_halt = 1'b0;
        end
      end else if (jif.jtag_req_i) begin
        m_act = 1'b1; m_wr = jif.jtag_we_i; m_addr = jif.jtag_addr_i; m_wdata = jif.jtag_wdata_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jreq(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    jif.jtag_req_i   = 1'b1;
    jif.jtag_we_i    = we;
    jif.jtag_addr_i  = addr;
    jif.jtag_wdata_i = data;
  endtask

  int acks0;
  logic halt_on;

  initial begin
`ifdef REGS_ARB_STARVE_HALT_EN
    halt_on = 1'b1;
`else
    halt_on = 1'b0;
`endif
    rst = 1'b1; mem_init = 1'b1;
    ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
    jif.jtag_req_i = 1'b0; jif.jtag_we_i = 1'b0; jif.jtag_addr_i = '0; jif.jtag_wdata_i = '0;
    repeat (2) tick();
    mem_init = 1'b0;
    rst = 1'b0;
    check("rst_ack",   32'(jif.jtag_ack_o),  32'd0);
    check("rst_busy",  32'(jif.jtag_busy_o), 32'd0);
    check("rst_rdata", jif.jtag_rdata_o,     32'd0);
    check("rst_raddr", 32'(rf_raddr),        32'd0);
    check("rst_halt",  32'(halt),            32'd0);

    // JTAG write x5, ex idle
    jreq(1'b1, 5'd5, 32'hDEADBEEF); tick(); jif.jtag_req_i = 1'b0;
    check("w5_rf_we",    32'(rf_we),    32'd1);
    check("w5_rf_waddr", 32'(rf_waddr), 32'd5);
    check("w5_rf_wdata", rf_wdata,      32'hDEADBEEF);
    check("w5_no_ack",   32'(jif.jtag_ack_o), 32'd0);
    tick(); check("w5_ack", 32'(jif.jtag_ack_o), 32'd1);
    tick(); check("w5_ack_drop", 32'(jif.jtag_ack_o), 32'd0);
    check("w5_idle", 32'(jif.jtag_busy_o), 32'd0);
    jreq(1'b0, 5'd5, 32'd0); tick(); jif.jtag_req_i = 1'b0;
    tick(); check("r5_ack", 32'(jif.jtag_ack_o), 32'd1);
    check("r5_rdata", jif.jtag_rdata_o, 32'hDEADBEEF);
    tick();

    // JTAG write x7 stalled by three ex writes
    acks0 = ack_cnt;
    jreq(1'b1, 5'd7, 32'h07070707); tick(); jif.jtag_req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex_we = 1'b1; ex_waddr = 5'(9 + k); ex_wdata = 32'hA000 + k; #1;
      check("stall_rf_waddr", 32'(rf_waddr), 32'(9 + k));
      check("stall_rf_wdata", rf_wdata,      32'hA000 + k);
      check("stall_no_ack",   32'(jif.jtag_ack_o), 32'd0);
      tick();
    end
    ex_we = 1'b0; #1;
    check("w7_rf_we",    32'(rf_we),    32'd1);
    check("w7_rf_waddr", 32'(rf_waddr), 32'd7);
    check("w7_rf_wdata", rf_wdata,      32'h07070707);
    tick(); check("w7_ack", 32'(jif.jtag_ack_o), 32'd1);
    tick(); check("w7_single_ack", 32'(ack_cnt - acks0), 32'd1);

    // Read x3 with same-cycle ex write to x3; ex writes x0 beforehand
    ex_we = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hAAAA; tick(); ex_we = 1'b0;
    jreq(1'b0, 5'd3, 32'd0); tick(); jif.jtag_req_i = 1'b0;
    ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h12345678; tick(); ex_we = 1'b0;
    check("r3_ack",   32'(jif.jtag_ack_o), 32'd1);
    check("r3_rdata", jif.jtag_rdata_o,    32'h12345678);
    tick();

    // Write and read x0
    jreq(1'b1, 5'd0, 32'hFFFFFFFF); tick(); jif.jtag_req_i = 1'b0;
    check("w0_no_rf_we", 32'(rf_we), 32'd0);
    tick(); check("w0_ack", 32'(jif.jtag_ack_o), 32'd1);
    tick();
    jreq(1'b0, 5'd0, 32'd0); tick(); jif.jtag_req_i = 1'b0;
    tick(); check("r0_ack", 32'(jif.jtag_ack_o), 32'd1);
    check("r0_rdata", jif.jtag_rdata_o, 32'd0);
    tick();

    // Starvation: ex held for six PEND cycles, released in the seventh
    jreq(1'b1, 5'd9, 32'h00000909); tick(); jif.jtag_req_i = 1'b0;
    ex_we = 1'b1; ex_waddr = 5'd20; ex_wdata = 32'h2020;
    for (int k = 1; k <= 6; k++) begin
      #1; check("starve_halt", 32'(halt), (k == 6) ? 32'(halt_on) : 32'd0);
      tick();
    end
    ex_we = 1'b0; #1;
    check("starve_halt_rel", 32'(halt),     32'(halt_on));
    check("starve_rf_waddr", 32'(rf_waddr), 32'd9);
    tick(); check("starve_halt_fall", 32'(halt), 32'd0);
    check("starve_ack", 32'(jif.jtag_ack_o), 32'd1);
    tick();

    // Reset while PEND drops the access
    acks0 = ack_cnt;
    jreq(1'b1, 5'd12, 32'h00C0FFEE); tick(); jif.jtag_req_i = 1'b0;
    rst = 1'b1; #1;
    check("rstp_no_rf_we", 32'(rf_we), 32'd0);
    tick(); rst = 1'b0;
    check("rstp_busy", 32'(jif.jtag_busy_o), 32'd0);
    check("rstp_ack",  32'(jif.jtag_ack_o),  32'd0);
    tick();
    check("rstp_mem12", mem[12], 32'h0000100C);
    check("rstp_no_acks", 32'(ack_cnt - acks0), 32'd0);
    jreq(1'b0, 5'd5, 32'd0); tick(); jif.jtag_req_i = 1'b0;
    tick(); check("post_rst_ack", 32'(jif.jtag_ack_o), 32'd1);
    check("post_rst_rdata", jif.jtag_rdata_o, 32'hDEADBEEF);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
